// File: rtl/vx_fp_classify_pipe_pkg.sv
// Shared FPU definitions: FCLASS mask bit positions, format codes and field widths.
package vx_fp_classify_pipe_pkg;

    localparam int unsigned FCLASS_WIDTH    = 10;
    localparam int unsigned FCLASS_NEG_INF  = 0;
    localparam int unsigned FCLASS_NEG_NORM = 1;
    localparam int unsigned FCLASS_NEG_SUB  = 2;
    localparam int unsigned FCLASS_NEG_ZERO = 3;
    localparam int unsigned FCLASS_POS_ZERO = 4;
    localparam int unsigned FCLASS_POS_SUB  = 5;
    localparam int unsigned FCLASS_POS_NORM = 6;
    localparam int unsigned FCLASS_POS_INF  = 7;
    localparam int unsigned FCLASS_SNAN     = 8;
    localparam int unsigned FCLASS_QNAN     = 9;

    localparam logic FMT_S = 1'b0;
    localparam logic FMT_D = 1'b1;

    localparam int unsigned FP32_EXP_BITS = 8;
    localparam int unsigned FP32_MAN_BITS = 23;
    localparam int unsigned FP64_EXP_BITS = 11;
    localparam int unsigned FP64_MAN_BITS = 52;

    typedef logic [FCLASS_WIDTH-1:0] fclass_t;

    // One-hot mask with only bit idx set.
    function automatic fclass_t fclass_bit(input int unsigned idx);
        return fclass_t'(1) << idx;
    endfunction

    localparam fclass_t FCLASS_CANON_NAN = fclass_t'(1) << FCLASS_QNAN;

endpackage

// File: rtl/vx_fp_classify_pipe_if.sv
// Request/response bundle of the classify unit; master = FPU side, slave = unit.
interface vx_fp_classify_pipe_if
    import vx_fp_classify_pipe_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TAG_WIDTH = 8
);
    logic                              valid_in;
    logic                              ready_in;
    logic                              fmt_in;
    logic [NUM_LANES-1:0]              lane_mask_in;
    logic [NUM_LANES*64-1:0]           data_in;
    logic [TAG_WIDTH-1:0]              tag_in;
    logic                              valid_out;
    logic                              ready_out;
    logic [NUM_LANES*FCLASS_WIDTH-1:0] class_out;
    logic [TAG_WIDTH-1:0]              tag_out;

    modport master (
        output valid_in, fmt_in, lane_mask_in, data_in, tag_in, ready_out,
        input  ready_in, valid_out, class_out, tag_out
    );

    modport slave (
        input  valid_in, fmt_in, lane_mask_in, data_in, tag_in, ready_out,
        output ready_in, valid_out, class_out, tag_out
    );

endinterface

// File: rtl/vx_fp_class_decode.sv
// Combinational FCLASS decode of one IEEE operand given as sign/exponent/mantissa.
module vx_fp_class_decode
    import vx_fp_classify_pipe_pkg::*;
#(
    parameter int unsigned EXP_BITS = 8,
    parameter int unsigned MAN_BITS = 23
) (
    input  logic                sign,
    input  logic [EXP_BITS-1:0] exponent,
    input  logic [MAN_BITS-1:0] mantissa,
    output fclass_t             class_mask
);

    logic exp_zero;
    logic exp_ones;
    logic man_zero;

    assign exp_zero = (exponent == '0);
    assign exp_ones = &exponent;
    assign man_zero = (mantissa == '0);

    // Pick the single class bit from the exponent/mantissa corner cases.
    always_comb begin
        class_mask = '0;
        if (exp_ones) begin
            if (man_zero) begin
                class_mask = fclass_bit(sign ? FCLASS_NEG_INF : FCLASS_POS_INF);
            end else if (mantissa[MAN_BITS-1]) begin
                class_mask = fclass_bit(FCLASS_QNAN);
            end else begin
                class_mask = fclass_bit(FCLASS_SNAN);
            end
        end else if (exp_zero) begin
            if (man_zero) begin
                class_mask = fclass_bit(sign ? FCLASS_NEG_ZERO : FCLASS_POS_ZERO);
            end else begin
                class_mask = fclass_bit(sign ? FCLASS_NEG_SUB : FCLASS_POS_SUB);
            end
        end else begin
            class_mask = fclass_bit(sign ? FCLASS_NEG_NORM : FCLASS_POS_NORM);
        end
    end

endmodule

// File: rtl/vx_fp_classify_pipe.sv
// Multi-lane FCLASS.S/FCLASS.D unit: decode, then a LATENCY-deep stallable register chain.
module vx_fp_classify_pipe
    import vx_fp_classify_pipe_pkg::*;
#(
    parameter int unsigned NUM_LANES = 4,
    parameter int unsigned TAG_WIDTH = 8,
    parameter int unsigned LATENCY   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    vx_fp_classify_pipe_if.slave  io
);

    localparam int unsigned CW = NUM_LANES * FCLASS_WIDTH;

    if (LATENCY < 1 || LATENCY > 4) begin : g_latency_check
        $error("vx_fp_classify_pipe: LATENCY must be in 1..4");
    end

    logic [CW-1:0] lane_class;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        logic [63:0] op;
        logic        boxed;
        fclass_t     cls_s;
        fclass_t     cls_d;
        fclass_t     cls;

        assign op    = io.data_in[64*i +: 64];
        assign boxed = &op[63:32];

        vx_fp_class_decode #(
            .EXP_BITS (FP32_EXP_BITS),
            .MAN_BITS (FP32_MAN_BITS)
        ) u_dec_s (
            .sign       (op[31]),
            .exponent   (op[30:23]),
            .mantissa   (op[22:0]),
            .class_mask (cls_s)
        );

        vx_fp_class_decode #(
            .EXP_BITS (FP64_EXP_BITS),
            .MAN_BITS (FP64_MAN_BITS)
        ) u_dec_d (
            .sign       (op[63]),
            .exponent   (op[62:52]),
            .mantissa   (op[51:0]),
            .class_mask (cls_d)
        );

        // Select by format; a badly boxed single reads as the canonical qNaN.
        always_comb begin
            cls = '0;
            if (io.lane_mask_in[i]) begin
                case (io.fmt_in)
                    FMT_S:   cls = boxed ? cls_s : FCLASS_CANON_NAN;
                    FMT_D:   cls = cls_d;
                    default: cls = '0;
                endcase
            end
        end

        assign lane_class[FCLASS_WIDTH*i +: FCLASS_WIDTH] = cls;
    end

    logic                 valid_q [LATENCY];
    logic [TAG_WIDTH-1:0] tag_q   [LATENCY];
    logic [CW-1:0]        class_q [LATENCY];
    logic                 stall;

    // Whole chain freezes while the last stage is held by the consumer.
    assign stall = valid_q[LATENCY-1] && !io.ready_out;

    // Pipeline register chain; stage 0 captures decoded masks, later stages only delay.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < LATENCY; s++) begin
                valid_q[s] <= 1'b0;
                tag_q[s]   <= '0;
                class_q[s] <= '0;
            end
        end else if (!stall) begin
            valid_q[0] <= io.valid_in;
            tag_q[0]   <= io.tag_in;
            class_q[0] <= lane_class;
            for (int s = 1; s < LATENCY; s++) begin
                valid_q[s] <= valid_q[s-1];
                tag_q[s]   <= tag_q[s-1];
                class_q[s] <= class_q[s-1];
            end
        end
    end

    assign io.ready_in  = !stall;
    assign io.valid_out = valid_q[LATENCY-1];
    assign io.tag_out   = tag_q[LATENCY-1];
    assign io.class_out = class_q[LATENCY-1];

endmodule

// File: tb/tb_vx_fp_classify_pipe.sv
// Bench for vx_fp_classify_pipe: three instances (LATENCY 2, 1, 4) share one driver,
// selected by sel; results are checked against a field-level FCLASS model.
module tb_vx_fp_classify_pipe;

    localparam int unsigned NL = 4;
    localparam int unsigned TW = 8;
    localparam int unsigned CW = NL * 10;

    logic          clk;
    logic          reset;
    logic [1:0]    sel;
    logic          valid_in;
    logic          fmt_in;
    logic [NL-1:0] lane_mask_in;
    logic [NL*64-1:0] data_in;
    logic [TW-1:0] tag_in;
    logic          ready_out;

    logic          ready_in_o;
    logic          valid_out_o;
    logic [CW-1:0] class_out_o;
    logic [TW-1:0] tag_out_o;

    int n_checks;
    int n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int unsigned LAT = (g == 0) ? 2 : ((g == 1) ? 1 : 4);

        vx_fp_classify_pipe_if #(.NUM_LANES(NL), .TAG_WIDTH(TW)) u_if ();

        assign u_if.valid_in     = valid_in && (sel == 2'(g));
        assign u_if.fmt_in       = fmt_in;
        assign u_if.lane_mask_in = lane_mask_in;
        assign u_if.data_in      = data_in;
        assign u_if.tag_in       = tag_in;
        assign u_if.ready_out    = ready_out;

        vx_fp_classify_pipe #(
            .NUM_LANES (NL),
            .TAG_WIDTH (TW),
            .LATENCY   (LAT)
        ) u_dut (
            .clk   (clk),
            .reset (reset),
            .io    (u_if.slave)
        );
    end

    // Route the selected instance's outputs to the checker.
    always_comb begin
        ready_in_o  = g_dut[0].u_if.ready_in;
        valid_out_o = g_dut[0].u_if.valid_out;
        class_out_o = g_dut[0].u_if.class_out;
        tag_out_o   = g_dut[0].u_if.tag_out;
        case (sel)
            2'd1: begin
                ready_in_o  = g_dut[1].u_if.ready_in;
                valid_out_o = g_dut[1].u_if.valid_out;
                class_out_o = g_dut[1].u_if.class_out;
                tag_out_o   = g_dut[1].u_if.tag_out;
            end
            2'd2: begin
                ready_in_o  = g_dut[2].u_if.ready_in;
                valid_out_o = g_dut[2].u_if.valid_out;
                class_out_o = g_dut[2].u_if.class_out;
                tag_out_o   = g_dut[2].u_if.tag_out;
            end
            default: ;
        endcase
    end

    function automatic int lat_of(input logic [1:0] s);
        return (s == 2'd0) ? 2 : ((s == 2'd1) ? 1 : 4);
    endfunction

    task automatic check_eq(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // FCLASS of one operand from its numeric fields.
    function automatic logic [9:0] ref_lane(input logic fmt, input logic [63:0] v);
        longint unsigned e, m, emax, qbit;
        bit s;
        int idx;
        if (!fmt) begin
            if (v[63:32] != 32'hFFFF_FFFF) return 10'h200;
            s = v[31]; e = 64'(v[30:23]); m = 64'(v[22:0]);
            emax = 255; qbit = 64'd1 << 22;
        end else begin
            s = v[63]; e = 64'(v[62:52]); m = 64'(v[51:0]);
            emax = 2047; qbit = 64'd1 << 51;
        end
        if (e == emax && m != 0) idx = (m >= qbit) ? 9 : 8;
        else if (e == emax)      idx = s ? 0 : 7;
        else if (e == 0 && m == 0) idx = s ? 3 : 4;
        else if (e == 0)         idx = s ? 2 : 5;
        else                     idx = s ? 1 : 6;
        return 10'd1 << idx;
    endfunction

    function automatic logic [CW-1:0] ref_req(input logic fmt, input logic [NL-1:0] mask,
                                              input logic [NL*64-1:0] data);
        logic [CW-1:0] r;
        r = '0;
        for (int l = 0; l < NL; l++)
            if (mask[l]) r[10*l +: 10] = ref_lane(fmt, data[64*l +: 64]);
        return r;
    endfunction

    // Random operand biased toward exponent/mantissa corner cases.
    function automatic logic [63:0] gen_op(input logic fmt);
        logic [63:0] v;
        int unsigned k;
        v = {$urandom, $urandom};
        k = $urandom_range(0, 5);
        if (fmt) begin
            case (k)
                0: v[62:52] = '0;
                1: v[62:52] = '1;
                2: begin v[62:52] = '0; v[51:0] = '0; end
                3: begin v[62:52] = '1; v[51:0] = '0; end
                default: ;
            endcase
        end else begin
            case (k)
                0: v[30:23] = '0;
                1: v[30:23] = '1;
                2: begin v[30:23] = '0; v[22:0] = '0; end
                3: begin v[30:23] = '1; v[22:0] = '0; end
                default: ;
            endcase
            if ($urandom_range(0, 7) != 0) v[63:32] = '1;
        end
        return v;
    endfunction

    // One request with ready_out high; checks accept, latency, class and tag.
    task automatic single_req(input string name, input logic fmt, input logic [NL-1:0] mask,
                              input logic [NL*64-1:0] data, input logic [TW-1:0] tag,
                              input logic [CW-1:0] exp_cls);
        int  lat;
        bit  seen;
        @(posedge clk); #1;
        ready_out = 1'b1; valid_in = 1'b1;
        fmt_in = fmt; lane_mask_in = mask; data_in = data; tag_in = tag;
        @(negedge clk);
        check_eq({name, " ready_in"}, 64'(ready_in_o), 64'd1);
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = 0; seen = 0;
        while (!seen && lat < 10) begin
            lat++;
            @(negedge clk);
            seen = valid_out_o;
        end
        check_eq({name, " latency"}, 64'(lat), 64'(lat_of(sel)));
        check_eq({name, " class"}, 64'(class_out_o), 64'(exp_cls));
        check_eq({name, " tag"}, 64'(tag_out_o), 64'(tag));
        @(negedge clk);
        check_eq({name, " no duplicate"}, 64'(valid_out_o), 64'd0);
    endtask

    typedef struct packed {
        logic [TW-1:0] tag;
        logic [CW-1:0] cls;
    } exp_t;

    logic             st_fmt  [64];
    logic [NL-1:0]    st_mask [64];
    logic [NL*64-1:0] st_data [64];
    logic [TW-1:0]    st_tag  [64];

    // Streams st_* through the selected DUT under backpressure with a scoreboard.
    task automatic run_stream(input string name, input int n, input bit rnd);
        exp_t          exp_q[$];
        exp_t          e;
        int            sent, got, cyc;
        bit            held, stall, acc;
        logic [CW-1:0] held_cls;
        logic [TW-1:0] held_tag;
        sent = 0; got = 0; cyc = 0; held = 0; held_cls = '0; held_tag = '0;
        @(posedge clk); #1;
        valid_in = 1'b1;
        fmt_in = st_fmt[0]; lane_mask_in = st_mask[0]; data_in = st_data[0]; tag_in = st_tag[0];
        ready_out = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
        while (got < n && cyc < 20 * n + 50) begin
            @(negedge clk);
            stall = valid_out_o && !ready_out;
            check_eq({name, " ready_in"}, 64'(ready_in_o), 64'(!stall));
            if (held) begin
                check_eq({name, " held valid"}, 64'(valid_out_o), 64'd1);
                check_eq({name, " held class"}, 64'(class_out_o), 64'(held_cls));
                check_eq({name, " held tag"}, 64'(tag_out_o), 64'(held_tag));
            end
            held = stall; held_cls = class_out_o; held_tag = tag_out_o;
            if (valid_out_o && ready_out) begin
                check_eq({name, " retire pending"}, 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check_eq({name, " tag"}, 64'(tag_out_o), 64'(e.tag));
                    check_eq({name, " class"}, 64'(class_out_o), 64'(e.cls));
                    got++;
                end
            end
            acc = valid_in && ready_in_o;
            if (acc) begin
                e.tag = st_tag[sent];
                e.cls = ref_req(st_fmt[sent], st_mask[sent], st_data[sent]);
                exp_q.push_back(e);
                sent++;
            end
            @(posedge clk); #1;
            cyc++;
            if (!valid_in || acc)
                valid_in = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
            if (sent < n) begin
                fmt_in = st_fmt[sent]; lane_mask_in = st_mask[sent];
                data_in = st_data[sent]; tag_in = st_tag[sent];
            end
            ready_out = rnd ? ($urandom_range(0, 2) != 0) : (cyc % 4 == 0 || cyc % 4 == 3);
        end
        valid_in = 1'b0; ready_out = 1'b1;
        check_eq({name, " retired count"}, 64'(got), 64'(n));
        check_eq({name, " leftover"}, 64'(exp_q.size()), 64'd0);
    endtask

    logic [63:0] dv [8];
    logic [9:0]  de [8];

    initial begin
        logic [NL*64-1:0] d;
        logic [CW-1:0]    x;
        int               stale;
        n_checks = 0; n_fail = 0;
        sel = 2'd0; valid_in = 1'b0; fmt_in = 1'b0; lane_mask_in = '0; data_in = '0;
        tag_in = '0; ready_out = 1'b1; reset = 1'b1;
        dv = '{64'h3FF0_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h7FF0_0000_0000_0001,
               64'h7FF8_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 64'hFFFF_FFFF_0000_0001,
               64'hFFFF_FFFF_7F80_0000, 64'h0000_0000_3F80_0000};
        de = '{10'h040, 10'h001, 10'h100, 10'h200, 10'h008, 10'h020, 10'h080, 10'h200};
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("reset valid_out", 64'(valid_out_o), 64'd0);
        check_eq("reset class_out", 64'(class_out_o), 64'd0);
        check_eq("reset tag_out", 64'(tag_out_o), 64'd0);
        check_eq("reset ready_in", 64'(ready_in_o), 64'd1);

        // Directed values at each latency; first four are fp64, last four fp32.
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            for (int k = 0; k < 8; k++) begin
                d = '0; d[63:0] = dv[k];
                x = '0; x[9:0] = de[k];
                single_req($sformatf("lat%0d val%0d", lat_of(sel), k), (k < 4) ? 1'b1 : 1'b0,
                           4'b0001, d, 8'(8'h40 + 16 * s + k), x);
            end
        end

        sel = 2'd0;
        single_req("lane mask", 1'b1, 4'b0101, {4{64'h3FF0_0000_0000_0000}}, 8'hA5,
                   {10'h000, 10'h040, 10'h000, 10'h040});

        for (int i = 0; i < 8; i++) begin
            st_fmt[i] = i[0]; st_mask[i] = '1; st_tag[i] = 8'(i);
            for (int l = 0; l < NL; l++) st_data[i][64*l +: 64] = gen_op(st_fmt[i]);
        end
        run_stream("stream", 8, 1'b0);

        // Reset with two requests in flight and the consumer stalled.
        @(posedge clk); #1;
        ready_out = 1'b0; valid_in = 1'b1; fmt_in = 1'b1; lane_mask_in = '1;
        data_in = {4{64'h3FF0_0000_0000_0000}}; tag_in = 8'h11;
        @(posedge clk); #1 tag_in = 8'h22;
        @(posedge clk); #1 valid_in = 1'b0; reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0; ready_out = 1'b1;
        @(negedge clk);
        check_eq("midreset valid_out", 64'(valid_out_o), 64'd0);
        check_eq("midreset class_out", 64'(class_out_o), 64'd0);
        check_eq("midreset tag_out", 64'(tag_out_o), 64'd0);
        check_eq("midreset ready_in", 64'(ready_in_o), 64'd1);
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (valid_out_o) stale++;
        end
        check_eq("midreset stale results", 64'(stale), 64'd0);
        d = '0; d[63:0] = 64'h7FF8_0000_0000_0000;
        single_req("after reset", 1'b1, 4'b0001, d, 8'h33, 40'h200);

        for (int i = 0; i < 40; i++) begin
            st_fmt[i] = 1'($urandom_range(0, 1)); st_mask[i] = 4'($urandom);
            st_tag[i] = 8'($urandom);
            for (int l = 0; l < NL; l++) st_data[i][64*l +: 64] = gen_op(st_fmt[i]);
        end
        run_stream("random", 40, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, limit 1000000 ns");
        $fatal(1, "watchdog");
    end

endmodule
